// File: rtl/operand_serializer_pkg.sv
// operand_serializer_pkg: shared defaults, FSM encoding and operand pair layout
package operand_serializer_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int DEPTH_DEF = 2;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  typedef struct packed {
    logic [WIDTH_DEF-1:0] x;
    logic [WIDTH_DEF-1:0] y;
  } pair_t;
endpackage

// File: rtl/operand_serializer_fifo.sv
// operand_fifo: synchronous circular buffer holding operand pairs
module operand_fifo
  import operand_serializer_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW = 2 * WIDTH_DEF
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full  = cnt_q == FULL_CNT;
  assign empty = cnt_q == '0;
  assign dout  = mem_q[rd_q];
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = (do_push && !do_pop) ? cnt_q + 1'b1 : (!do_push && do_pop) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge CLK) if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/operand_serializer.sv
// operand_serializer: buffers parallel operand pairs and shifts them out LSB-first with framing strobes
module operand_serializer
  import operand_serializer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             bit_ready,
  output logic             bit_valid,
  output logic             x_bit,
  output logic             y_bit,
  output logic             first_bit,
  output logic             last_bit,
  output logic             busy
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] x_sr_q, x_sr_d, y_sr_q, y_sr_d;
  logic [2*WIDTH-1:0] head;
  logic pop, full, empty;
  operand_fifo #(.DEPTH(DEPTH), .DW(2 * WIDTH)) u_fifo (
    .CLK(CLK),
    .reset_n(reset_n),
    .push(in_valid && in_ready),
    .pop(pop),
    .din({in_x, in_y}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign in_ready  = !full;
  assign bit_valid = state_q == SHIFT;
  assign x_bit     = x_sr_q[0];
  assign y_bit     = y_sr_q[0];
  assign first_bit = bit_valid && cnt_q == '0;
  assign last_bit  = bit_valid && cnt_q == LAST;
  assign busy      = bit_valid || !empty;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    x_sr_d = x_sr_q;
    y_sr_d = y_sr_q;
    pop = !empty && (state_q == IDLE || (bit_ready && cnt_q == LAST));
    if (pop) begin
      state_d = SHIFT;
      cnt_d = '0;
      {x_sr_d, y_sr_d} = head;
    end else if (state_q == SHIFT && bit_ready) begin
      state_d = cnt_q == LAST ? IDLE : SHIFT;
      cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
      x_sr_d = cnt_q == LAST ? '0 : x_sr_q >> 1;
      y_sr_d = cnt_q == LAST ? '0 : y_sr_q >> 1;
    end
  end
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      x_sr_q <= '0;
      y_sr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      x_sr_q <= x_sr_d;
      y_sr_q <= y_sr_d;
    end
  end
endmodule

// File: tb/tb_operand_serializer.sv
// tb_operand_serializer: directed and random checks against a beat-stream reference model
module tb_operand_serializer;
  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [WIDTH-1:0] in_x = '0;
  logic [WIDTH-1:0] in_y = '0;
  logic bit_ready = 1'b0;
  logic bit_valid, x_bit, y_bit, first_bit, last_bit, busy;
  int n_chk = 0;
  int n_fail = 0;
  logic [4:0] beats [$];
  int outstanding = 0;
  logic prev_stall = 1'b0;
  logic [4:0] prev_out = '0;
  operand_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(clk),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_x(in_x),
    .in_y(in_y),
    .bit_ready(bit_ready),
    .bit_valid(bit_valid),
    .x_bit(x_bit),
    .y_bit(y_bit),
    .first_bit(first_bit),
    .last_bit(last_bit),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    bit_ready = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
  endtask
  task automatic drain();
    int n;
    in_valid = 1'b0;
    bit_ready = 1'b1;
    n = 0;
    while ((busy || bit_valid) && n < 200) begin
      cyc();
      n++;
    end
    check("drain_done", 32'(n < 200), 1);
    check("drain_left", beats.size(), 0);
  endtask
  // Model: every accepted pair becomes WIDTH ordered beats {0,x,y,first,last}; pairs are outstanding until their last beat is taken
  always @(negedge clk) begin
    if (!reset_n) begin
      beats.delete();
      outstanding = 0;
      prev_stall = 1'b0;
    end else begin
      logic [4:0] exp;
      check("in_ready", in_ready, 32'(outstanding < DEPTH + 1));
      check("busy", busy, 32'(outstanding > 0));
      if (prev_stall) check("stall_hold", {bit_valid, x_bit, y_bit, first_bit, last_bit}, prev_out);
      prev_stall = bit_valid && !bit_ready;
      prev_out = {bit_valid, x_bit, y_bit, first_bit, last_bit};
      if (bit_valid && bit_ready) begin
        exp = beats.size() > 0 ? beats.pop_front() : 5'h10;
        check("beat", {1'b0, x_bit, y_bit, first_bit, last_bit}, exp);
        if (exp[0]) outstanding--;
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < WIDTH; i++) beats.push_back({1'b0, in_x[i], in_y[i], i == 0, i == WIDTH - 1});
        outstanding++;
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int nv, first_i, last_i, acc;
    repeat (3) cyc();
    check("reset_out", {in_ready, bit_valid, x_bit, y_bit, first_bit, last_bit, busy}, 7'b1000000);
    reset_n = 1'b1;
    cyc();
    // single operand, no stall
    in_valid = 1'b1; in_x = 4'b1010; in_y = 4'b0111; bit_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("bubble", bit_valid, 0);
    cyc();
    check("first_beat", {bit_valid, first_bit, x_bit, y_bit}, 4'b1101);
    nv = 1;
    repeat (8) begin
      cyc();
      nv += int'(bit_valid);
    end
    check("single_beats", nv, 4);
    check("single_idle", busy, 0);
    // back-to-back operands
    in_valid = 1'b1; in_x = 4'b1010; in_y = 4'b0111;
    cyc();
    in_x = 4'b1111; in_y = 4'b1111;
    cyc();
    in_valid = 1'b0;
    nv = 0; first_i = -1; last_i = -1;
    for (int i = 0; i < 20; i++) begin
      if (bit_valid) begin
        nv++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
      cyc();
    end
    check("b2b_beats", nv, 8);
    check("b2b_span", last_i - first_i + 1, 8);
    drain();
    // full FIFO under stall
    do_reset();
    in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      in_x = 4'($urandom); in_y = 4'($urandom);
      acc += int'(in_ready);
      cyc();
    end
    check("full_accepted", acc, 3);
    check("full_ready", in_ready, 0);
    in_valid = 1'b0;
    bit_ready = 1'b1;
    repeat (3) cyc();
    check("full_still", in_ready, 0);
    cyc();
    check("full_reopen", in_ready, 1);
    drain();
    // stall on beat 2
    in_valid = 1'b1; in_x = 4'b1010; in_y = 4'b0111; bit_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    bit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_beat2", {bit_valid, x_bit, y_bit, first_bit}, 4'b1110);
    end
    drain();
    // reset in the middle of beat 3 with one pair queued
    in_valid = 1'b1; in_x = 4'b1010; in_y = 4'b0111; bit_ready = 1'b1;
    cyc();
    in_x = 4'b0101; in_y = 4'b1001;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    check("pre_reset", {bit_valid, first_bit, last_bit}, 3'b100);
    #1 reset_n = 1'b0;
    #1 check("async_reset", {in_ready, bit_valid, x_bit, y_bit, first_bit, last_bit, busy}, 7'b1000000);
    cyc();
    reset_n = 1'b1;
    nv = 0;
    repeat (6) begin
      cyc();
      nv += int'(bit_valid);
    end
    check("no_residual", nv, 0);
    check("post_reset", {busy, in_ready}, 2'b01);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_x = 4'($urandom);
      in_y = 4'($urandom);
      bit_ready = $urandom_range(0, 3) != 0;
      cyc();
    end
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/operand_serializer.md
Name: operand_serializer

Overview:
Upstream feeder for the bit-serial adder. Accepts parallel operand pairs (x, y) through a valid/ready handshake and buffers them in a small FIFO. Shifts each pair out LSB-first, one bit pair per cycle, with framing strobes that tell the adder when to clear and when to capture its carry. Supports back-to-back operands with no idle cycle between them, and a downstream stall.

Parameters:
WIDTH, 4, operand width in bits (matches the adder's x/y width)
DEPTH, 2, operand-pair FIFO depth in entries (power of two, >=2)

Ports:
CLK  input  1  system clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  upstream presents an operand pair
in_ready  output  1  FIFO can accept a pair this cycle
in_x  input  WIDTH  operand x
in_y  input  WIDTH  operand y
bit_ready  input  1  downstream consumes the current bit pair this cycle
bit_valid  output  1  x_bit/y_bit/strobes are valid
x_bit  output  1  current bit of x, LSB first
y_bit  output  1  current bit of y, LSB first
first_bit  output  1  current bit is bit 0 (adder clears carry)
last_bit  output  1  current bit is bit WIDTH-1 (adder captures final carry)
busy  output  1  shifter active or FIFO non-empty

Behaviour:
- Reset (async assert, sync release): FIFO empty, state IDLE, counter 0, shift registers 0. in_ready=1; bit_valid, x_bit, y_bit, first_bit, last_bit and busy all 0.
- Push: occurs when in_valid && in_ready. in_ready = !fifo_full and is combinational from the count only. A pop in the same cycle does not open a slot in a full FIFO.
- FSM states: IDLE, SHIFT.
- IDLE: if FIFO is non-empty, pop the head into x_sr/y_sr, set cnt=0, go to SHIFT. A pair pushed into an empty FIFO at edge N is loaded at edge N+1, so bit_valid first goes high in the cycle after N+1 (1-cycle bubble).
- SHIFT outputs:
  - bit_valid=1
  - x_bit=x_sr[0], y_bit=y_sr[0]
  - first_bit=(cnt==0), last_bit=(cnt==WIDTH-1)
- SHIFT, bit_ready=1 and cnt<WIDTH-1: shift both registers right by 1 and increment cnt.
- SHIFT, bit_ready=1 and cnt==WIDTH-1:
  - If the FIFO is non-empty, pop and load the next pair with cnt=0, staying in SHIFT (no bubble).
  - Otherwise go to IDLE.
- SHIFT, bit_ready=0: all outputs and state held stable (stall).
- Pop and push in the same cycle on a non-full FIFO: both occur, count unchanged.
- Counter width is clog2(WIDTH); wrap is explicit (reload to 0), never natural overflow.
- busy = (state==SHIFT) || !fifo_empty.
- Outputs bit_valid, x_bit, y_bit, first_bit and last_bit come directly from registers, with no combinational path from bit_ready.
- Reset mid-operation: an in-flight pair and all buffered pairs are discarded, and all outputs return to reset values immediately.

Decomposition:
- Shared package: WIDTH default, state encoding (IDLE=0, SHIFT=1), and a pair struct/concatenation {x, y} of 2*WIDTH bits.
- Sub-module: operand_fifo (parameters DEPTH and data width 2*WIDTH; ports CLK, reset_n, push, pop, din, dout, full, empty). It is a synchronous circular buffer with read/write pointers and a count.
- The serializer FSM and shifter live in operand_serializer.

Test Plan:
- Single op, no stall:
  - Stimulus: after reset, push x=1010, y=0111, hold bit_ready=1.
  - Response: bit_valid high for exactly 4 cycles.
  - x_bit sequence is 0,1,0,1; y_bit sequence is 1,1,1,0.
  - first_bit only on beat 1, last_bit only on beat 4; then busy=0.
- Back-to-back:
  - Stimulus: push 1010/0111, then 1111/1111 while the first is shifting.
  - Response: 8 consecutive valid beats with no gap.
  - Beats 5-8 have x_bit=1 and y_bit=1; first_bit on beats 1 and 5, last_bit on beats 4 and 8.
- Full:
  - Stimulus: bit_ready=0, in_valid=1 every cycle from reset release.
  - Response: exactly 3 pairs accepted (1 in shifter, 2 in FIFO), then in_ready=0.
  - Raising bit_ready reasserts in_ready on the cycle after the first load from the FIFO.
- Stall:
  - Stimulus: drop bit_ready for 3 cycles on beat 2 of 1010/0111.
  - Response: x_bit=1, y_bit=1, first_bit=0 held for all 3 cycles; the sequence resumes intact.
- Reset mid-op:
  - Stimulus: assert reset_n=0 between clock edges during beat 3 with one pair queued.
  - Response: outputs go to reset values without waiting for a clock edge.
  - After release, no residual beats; busy=0 and in_ready=1.
